// File: rtl/fp_recode_multi_pipeline.sv
// fp_recode_multi_pipeline: converts IEEE single or double operands to the
// recoded format. The conversion runs in front of a DEPTH-stage valid/ready
// pipeline. Stalls back-pressure per stage and bubbles collapse. An opaque tag
// travels with each op.
//
// Optional feature macro: FPU_RECODE_SNAN_EXC_EN. When it is defined, exc[4]
// (NV) is raised for signalling-NaN inputs. When it is undefined, exc is
// constant 0.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_val/in_rdy     input handshake; in_rdy depends combinationally on out_rdy
//   in, in_sp, in_tag operand (SP uses in[31:0]), precision select, tag
//   out_val/out_rdy   output handshake
//   result            recoded value (SP zero-extended from [32:0])
//   out_sp, out_tag   precision and tag of the result
//   exc               exception flags of the result

`ifndef FPR_WIDTH
`define FPR_WIDTH 64
`endif
`ifndef FPR_RECODED_WIDTH
`define FPR_RECODED_WIDTH 65
`endif
`ifndef FPU_EXC_WIDTH
`define FPU_EXC_WIDTH 5
`endif

// Combinational IEEE (EW,SW) -> recoded (EW+1 exponent bits) conversion
module fp_recode_multi_pipeline_rec #(
    parameter int unsigned EW = 11,
    parameter int unsigned SW = 53
) (
    input  logic [EW+SW-1:0] fp,
    output logic [EW+SW:0]   rec
);
    localparam int unsigned FW = SW - 1;
    localparam int unsigned DW = $clog2(FW + 1);
    localparam logic [EW:0] OFS = (EW+1)'((1 << (EW - 1)) + 1);

    logic          sign;
    logic [EW-1:0] exp_in;
    logic [FW-1:0] fract;
    logic [FW-1:0] sub_fract;
    logic [DW-1:0] norm_dist;
    logic [EW:0]   adj_exp;
    logic [EW:0]   exp_out;
    logic          exp_zero;
    logic          fract_zero;

    assign sign   = fp[EW+SW-1];
    assign exp_in = fp[EW+SW-2:FW];
    assign fract  = fp[FW-1:0];

    always_comb begin
        // leading-zero count of the fraction; the last hit is the highest set bit
        norm_dist = DW'(FW);
        for (int i = 0; i < int'(FW); i++) begin
            if (fract[i]) norm_dist = DW'(int'(FW) - 1 - i);
        end
        // subnormal: shift the leading one out of the fraction field
        sub_fract  = (fract << norm_dist) << 1;
        exp_zero   = (exp_in == '0);
        fract_zero = (fract == '0);
        adj_exp    = exp_zero ? (OFS - (EW+1)'(norm_dist)) : ({1'b0, exp_in} + OFS);
        exp_out    = adj_exp;
        if (exp_zero && fract_zero) begin
            exp_out = '0;
        end else if ((adj_exp[EW:EW-1] == 2'b11) && !fract_zero) begin
            exp_out[EW-2] = 1'b1;
        end
        rec = {sign, exp_out, exp_zero ? sub_fract : fract};
    end
endmodule

module fp_recode_multi_pipeline #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_val,
    output logic                          in_rdy,
    input  logic [`FPR_WIDTH-1:0]         in,
    input  logic                          in_sp,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [`FPR_RECODED_WIDTH-1:0] result,
    output logic                          out_sp,
    output logic [TAG_W-1:0]              out_tag,
    output logic [`FPU_EXC_WIDTH-1:0]     exc
);
    localparam int unsigned RW = `FPR_RECODED_WIDTH;
    localparam int unsigned XW = `FPU_EXC_WIDTH;

    logic [32:0]      rec_sp;
    logic [64:0]      rec_dp;
    logic [RW-1:0]    rec_sel;
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] sp_q;
    logic [DEPTH-1:0] ld;
    logic [RW-1:0]    data_q [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];

    fp_recode_multi_pipeline_rec #(.EW(8), .SW(24)) u_rec_sp (.fp(in[31:0]), .rec(rec_sp));
    fp_recode_multi_pipeline_rec #(.EW(11), .SW(53)) u_rec_dp (.fp(in), .rec(rec_dp));

    assign rec_sel = in_sp ? RW'(rec_sp) : rec_dp;

    // Stage s can load when it, or any stage after it, is empty, or the
    // consumer is taking the head; equivalent to ~v[s] | adv[s].
    always_comb begin
        ld = '0;
        for (int s = 0; s < int'(DEPTH); s++) begin
            ld[s] = out_rdy;
            for (int k = s; k < int'(DEPTH); k++) begin
                if (!v_q[k]) ld[s] = 1'b1;
            end
        end
    end

    assign in_rdy = reset | ld[0];

    // Pipeline stage registers
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q  <= '0;
            sp_q <= '0;
            for (int s = 0; s < int'(DEPTH); s++) begin
                data_q[s] <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            if (ld[0]) begin
                v_q[0]    <= in_val;
                data_q[0] <= rec_sel;
                sp_q[0]   <= in_sp;
                tag_q[0]  <= in_tag;
            end
            for (int s = 1; s < int'(DEPTH); s++) begin
                if (ld[s]) begin
                    v_q[s]    <= v_q[s-1];
                    data_q[s] <= data_q[s-1];
                    sp_q[s]   <= sp_q[s-1];
                    tag_q[s]  <= tag_q[s-1];
                end
            end
        end
    end

    assign out_val = v_q[DEPTH-1];
    assign result  = data_q[DEPTH-1];
    assign out_sp  = sp_q[DEPTH-1];
    assign out_tag = tag_q[DEPTH-1];

`ifdef FPU_RECODE_SNAN_EXC_EN
    logic          snan_c;
    logic [XW-1:0] exc_in;
    logic [XW-1:0] exc_q [DEPTH];

    // Signalling NaN: max exponent, nonzero fraction, quiet bit clear
    always_comb begin
        if (in_sp) begin
            snan_c = (&in[30:23]) && (in[22:0] != '0) && !in[22];
        end else begin
            snan_c = (&in[62:52]) && (in[51:0] != '0) && !in[51];
        end
        exc_in    = '0;
        exc_in[4] = snan_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(DEPTH); s++) exc_q[s] <= '0;
        end else begin
            if (ld[0]) exc_q[0] <= exc_in;
            for (int s = 1; s < int'(DEPTH); s++) begin
                if (ld[s]) exc_q[s] <= exc_q[s-1];
            end
        end
    end

    assign exc = exc_q[DEPTH-1];
`else
    assign exc = '0;
`endif
endmodule

// File: tb/tb_fp_recode_multi_pipeline.sv
// Self-checking bench for fp_recode_multi_pipeline (DEPTH=2, TAG_W=5).
module tb_fp_recode_multi_pipeline;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned TAG_W = 5;
`ifdef FPU_RECODE_SNAN_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [63:0] in;
    logic        in_sp;
    logic [4:0]  in_tag;
    logic        out_val;
    logic        out_rdy;
    logic [64:0] result;
    logic        out_sp;
    logic [4:0]  out_tag;
    logic [4:0]  exc;

    always #5 clk = ~clk;

    fp_recode_multi_pipeline #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in(in),
        .in_sp(in_sp), .in_tag(in_tag), .out_val(out_val), .out_rdy(out_rdy),
        .result(result), .out_sp(out_sp), .out_tag(out_tag), .exc(exc)
    );

    typedef struct packed {
        logic [64:0] res;
        logic        sp;
        logic [4:0]  tag;
        logic [4:0]  exc;
    } item_t;

    typedef struct {
        logic [63:0] x;
        bit          sp;
        logic [64:0] res;
        bit          snan;
    } vec_t;

    item_t sb[$];
    int    total = 0;
    int    bad = 0;
    bit    hold_pend = 1'b0;
    item_t hold_val;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference: classify the IEEE value and build the recoded fields from
    // the unbiased exponent (recoded exponent = unbiased + 2^ew).
    function automatic item_t model(input logic [63:0] x, input bit sp, input logic [4:0] tag);
        int              ew, fw, bias, e, p, unb;
        logic            sign;
        longint unsigned fr, mask;
        logic [11:0]     rexp;
        item_t           it;
        ew   = sp ? 8 : 11;
        fw   = sp ? 23 : 52;
        bias = (1 << (ew - 1)) - 1;
        mask = (64'd1 << fw) - 64'd1;
        if (sp) begin
            sign = x[31]; e = int'(x[30:23]); fr = 64'(x[22:0]);
        end else begin
            sign = x[63]; e = int'(x[62:52]); fr = 64'(x[51:0]);
        end
        it.exc = (EXC_EN && (e == (1 << ew) - 1) && (fr != 0) && (fr[fw-1] == 1'b0)) ? 5'b10000 : 5'b0;
        if (e == 0 && fr == 0) begin
            rexp = 12'd0;
        end else if (e == (1 << ew) - 1) begin
            rexp = 12'(((fr == 0) ? 6 : 7) << (ew - 2));
        end else if (e == 0) begin
            p = 0;
            for (int i = 0; i < fw; i++) if (fr[i]) p = i;
            unb  = 1 - bias - (fw - p);
            rexp = 12'(unb + (1 << ew));
            fr   = (fr << (fw - p)) & mask;
        end else begin
            rexp = 12'(e - bias + (1 << ew));
        end
        it.res = (65'(sign) << (ew + 1 + fw)) | (65'(rexp) << fw) | 65'(fr);
        it.sp  = sp;
        it.tag = tag;
        return it;
    endfunction

    function automatic logic [63:0] rand_op(input bit sp);
        logic [63:0] r;
        int          k;
        r = {$urandom, $urandom};
        k = $urandom_range(0, 6);
        if (sp) begin
            case (k)
                1: r[30:0] = 31'd0;
                2: r[30:0] = {8'hFF, 23'd0};
                3: r[30:22] = 9'h1FF;
                4: begin r[30:22] = {8'hFF, 1'b0}; if (r[21:0] == 22'd0) r[0] = 1'b1; end
                5: r[30:23] = 8'd0;
                default: ;
            endcase
        end else begin
            case (k)
                1: r[62:0] = 63'd0;
                2: r[62:0] = {11'h7FF, 52'd0};
                3: r[62:51] = 12'hFFF;
                4: begin r[62:51] = {11'h7FF, 1'b0}; if (r[50:0] == 51'd0) r[0] = 1'b1; end
                5: r[62:52] = 11'd0;
                default: ;
            endcase
        end
        return r;
    endfunction

    // One clock: drive at negedge, settle, then score what the next posedge transfers.
    task automatic cycle(input bit iv, input logic [63:0] x, input bit sp, input logic [4:0] tag,
                         input item_t expv, input bit ordy, output bit acc, output bit rdy);
        item_t got, want;
        @(negedge clk);
        in_val = iv; in = x; in_sp = sp; in_tag = tag; out_rdy = ordy;
        #1;
        got = {result, out_sp, out_tag, exc};
        if (hold_pend) chk("hold_stable", 80'({got, out_val}), 80'({hold_val, 1'b1}));
        hold_pend = out_val && !out_rdy;
        hold_val  = got;
        if (out_val && out_rdy) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 80'(out_val), 80'(1'b0));
            end else begin
                want = sb.pop_front();
                chk("out_item", 80'(got), 80'(want));
            end
        end
        rdy = in_rdy;
        acc = iv && in_rdy;
        if (acc) sb.push_back(expv);
    endtask

    task automatic idle(input bit ordy);
        bit a, r;
        cycle(1'b0, 64'd0, 1'b0, 5'd0, model(64'd0, 1'b0, 5'd0), ordy, a, r);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1'b1);
        chk("drained", 80'(sb.size()), 80'(0));
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1; in_val = 1'b0; out_rdy = 1'b1;
        #1 chk("rdy_in_reset", 80'(in_rdy), 80'(1'b1));
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_val", 80'(out_val), 80'(1'b0));
        chk("rst_in_rdy", 80'(in_rdy), 80'(1'b1));
        chk("rst_outputs", 80'({result, out_sp, out_tag, exc}), 80'(0));
        sb.delete();
        hold_pend = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[11];
        item_t       e;
        bit          acc, rdy, saw_low, have, rsp;
        int          n;
        logic [63:0] ops[6];
        logic [63:0] rx;
        logic [4:0]  rtag;
        bit          pat[8];

        tbl[0]  = '{64'h3FF0_0000_0000_0000, 1'b0, 65'h0_8000_0000_0000_0000, 1'b0};
        tbl[1]  = '{64'h0000_0000_3F80_0000, 1'b1, 65'h0_0000_0000_8000_0000, 1'b0};
        tbl[2]  = '{64'h0000_0000_0000_0000, 1'b1, 65'h0_0000_0000_0000_0000, 1'b0};
        tbl[3]  = '{64'h8000_0000_0000_0000, 1'b0, 65'h1_0000_0000_0000_0000, 1'b0};
        tbl[4]  = '{64'h7FF0_0000_0000_0001, 1'b0, 65'h0_E000_0000_0000_0001, 1'b1};
        tbl[5]  = '{64'h7FF8_0000_0000_0000, 1'b0, 65'h0_E008_0000_0000_0000, 1'b0};
        tbl[6]  = '{64'h7FF0_0000_0000_0000, 1'b0, 65'h0_C000_0000_0000_0000, 1'b0};
        tbl[7]  = '{64'h0000_0000_BF80_0000, 1'b1, 65'h0_0000_0001_8000_0000, 1'b0};
        tbl[8]  = '{64'h0000_0000_0000_0001, 1'b0, 65'h0_3CE0_0000_0000_0000, 1'b0};
        tbl[9]  = '{64'hDEAD_BEEF_7F80_0001, 1'b1, 65'h0_0000_0000_E000_0001, 1'b1};
        tbl[10] = '{64'h0000_0000_4000_0000, 1'b1, 65'h0_0000_0000_8080_0000, 1'b0};

        reset = 1'b1; in_val = 1'b0; in = '0; in_sp = 1'b0; in_tag = '0; out_rdy = 1'b1;
        do_reset(2);

        // directed table, one op per cycle
        foreach (tbl[i]) begin
            e.res = tbl[i].res;
            e.sp  = tbl[i].sp;
            e.tag = 5'(i);
            e.exc = (tbl[i].snan && EXC_EN) ? 5'b10000 : 5'b00000;
            cycle(1'b1, tbl[i].x, tbl[i].sp, 5'(i), e, 1'b1, acc, rdy);
        end
        drain();

        // latency from an empty pipe
        cycle(1'b1, 64'h3FF0_0000_0000_0000, 1'b0, 5'd3,
              model(64'h3FF0_0000_0000_0000, 1'b0, 5'd3), 1'b1, acc, rdy);
        for (int i = 1; i <= int'(DEPTH); i++) begin
            idle(1'b1);
            chk("latency_out_val", 80'(out_val), 80'(i == int'(DEPTH)));
        end
        drain();

        // six ops back-to-back, consumer stalls for cycles 3-5
        for (int i = 0; i < 6; i++) ops[i] = rand_op(1'b0);
        n = 0; saw_low = 1'b0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            cycle(1'b1, ops[n], 1'b0, 5'(10 + n), model(ops[n], 1'b0, 5'(10 + n)),
                  !(c >= 3 && c <= 5), acc, rdy);
            if (!rdy) saw_low = 1'b1;
            if (acc) n++;
        end
        chk("stream_all_in", 80'(n), 80'(6));
        chk("stream_rdy_dropped", 80'(saw_low), 80'(1'b1));
        drain();

        // full pipe: no room while stalled, swap when consumer takes the head
        for (int i = 0; i < int'(DEPTH); i++)
            cycle(1'b1, ops[i], 1'b0, 5'(20 + i), model(ops[i], 1'b0, 5'(20 + i)), 1'b0, acc, rdy);
        cycle(1'b1, ops[5], 1'b0, 5'd29, model(ops[5], 1'b0, 5'd29), 1'b0, acc, rdy);
        chk("full_in_rdy", 80'(rdy), 80'(1'b0));
        cycle(1'b1, ops[5], 1'b0, 5'd29, model(ops[5], 1'b0, 5'd29), 1'b1, acc, rdy);
        chk("full_swap_rdy", 80'(rdy), 80'(1'b1));
        drain();

        // bubbles preserved with out_rdy high
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 8 + int'(DEPTH); c++) begin
            rx = rand_op(1'b1);
            cycle((c < 8) ? pat[c % 8] : 1'b0, rx, 1'b1, 5'(c), model(rx, 1'b1, 5'(c)), 1'b1, acc, rdy);
            chk("bubble_gap", 80'(out_val), 80'((c >= int'(DEPTH)) ? pat[c - int'(DEPTH)] : 1'b0));
        end
        drain();

        // bubbles collapse under stall
        n = 0;
        for (int c = 0; c < 8; c++) begin
            rx = rand_op(1'b0);
            cycle((c == 1) ? 1'b0 : 1'b1, rx, 1'b0, 5'(c), model(rx, 1'b0, 5'(c)), 1'b0, acc, rdy);
            if (acc) n++;
        end
        chk("bubble_fill", 80'(n), 80'(DEPTH));
        drain();

        // reset mid-flight discards everything
        for (int i = 0; i < int'(DEPTH); i++)
            cycle(1'b1, ops[i], 1'b0, 5'(i), model(ops[i], 1'b0, 5'(i)), 1'b0, acc, rdy);
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            chk("post_reset_quiet", 80'(out_val), 80'(1'b0));
        end

        // randomized traffic against the model; the source holds an op until taken
        have = 1'b0; rx = '0; rsp = 1'b0; rtag = '0;
        for (int c = 0; c < 400; c++) begin
            if (!have && ($urandom_range(0, 3) != 0)) begin
                rsp  = 1'($urandom_range(0, 1));
                rx   = rand_op(rsp);
                rtag = 5'($urandom);
                have = 1'b1;
            end
            cycle(have, rx, rsp, rtag, model(rx, rsp, rtag), ($urandom_range(0, 3) != 0), acc, rdy);
            if (acc) have = 1'b0;
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
